// File: rtl/div_color_multi.sv
// N-class colour segmentation stage. Each pixel is tested against NCLS
// programmable colour classes (SAD tolerance plus brightness window); the
// lowest-index matching class wins. Class references are written into a
// shadow bank and copied to the active bank atomically at frame start.
// Four-stage pipeline: 1 pixel/clk, no backpressure, 4-cycle latency.

`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif

module div_color_multi #(
  parameter int               C_W        = `COLOR_WIDTH,
  parameter int               NCLS       = 4,
  parameter int               IDX_W      = 3,
  parameter bit               PASS_RAW   = 1'b0,
  parameter logic [3*C_W-1:0] MISS_COLOR = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             i_frame_start,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [C_W-1:0]   cfg_R0,
  input  logic [C_W-1:0]   cfg_G0,
  input  logic [C_W-1:0]   cfg_B0,
  input  logic [C_W+1:0]   cfg_err,
  input  logic [C_W+1:0]   cfg_Vmin,
  input  logic [C_W+1:0]   cfg_Vmax,
  input  logic [C_W-1:0]   cfg_Rc,
  input  logic [C_W-1:0]   cfg_Gc,
  input  logic [C_W-1:0]   cfg_Bc,
  input  logic             i_valid,
  input  logic [C_W-1:0]   i_R,
  input  logic [C_W-1:0]   i_G,
  input  logic [C_W-1:0]   i_B,
  output logic             o_valid,
  output logic [C_W-1:0]   o_R,
  output logic [C_W-1:0]   o_G,
  output logic [C_W-1:0]   o_B,
  output logic [C_W-1:0]   o_R_raw,
  output logic [C_W-1:0]   o_G_raw,
  output logic [C_W-1:0]   o_B_raw,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_cls,
  output logic [NCLS-1:0]  o_hit_vec
);

  // SAD and V sums of three C_W-bit terms fit in C_W+2 bits without overflow.
  localparam int V_W   = C_W + 2;
  localparam int PIX_W = 3 * C_W;

  // Full class entry as written through the config port.
  typedef struct packed {
    logic             en;
    logic [C_W-1:0]   r0;
    logic [C_W-1:0]   g0;
    logic [C_W-1:0]   b0;
    logic [V_W-1:0]   err;
    logic [V_W-1:0]   vmin;
    logic [V_W-1:0]   vmax;
    logic [PIX_W-1:0] rep;
  } cls_cfg_t;

  // Per-pixel thresholds that travel with the pixel after S1.
  typedef struct packed {
    logic             en;
    logic [V_W-1:0]   err;
    logic [V_W-1:0]   vmin;
    logic [V_W-1:0]   vmax;
    logic [PIX_W-1:0] rep;
  } cls_thr_t;

  function automatic logic [C_W-1:0] abs_diff(input logic [C_W-1:0] a,
                                              input logic [C_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // ---------------------------------------------------------------------
  // Config banks
  // ---------------------------------------------------------------------
  cls_cfg_t shadow_q [NCLS];
  cls_cfg_t shadow_d [NCLS];
  cls_cfg_t active_q [NCLS];
  cls_cfg_t active_d [NCLS];
  logic     pending_q, pending_d;
  cls_cfg_t cfg_word;

  assign cfg_word = '{en: cfg_en, r0: cfg_R0, g0: cfg_G0, b0: cfg_B0,
                      err: cfg_err, vmin: cfg_Vmin, vmax: cfg_Vmax,
                      rep: {cfg_Rc, cfg_Gc, cfg_Bc}};

  // Commit shadow to active on frame start, then land any config write in shadow.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    // The commit copies shadow_q, so a coincident write waits for the next frame.
    if (i_frame_start && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // Out-of-range indices match no entry and leave pending untouched.
    for (int k = 0; k < NCLS; k++) begin
      if (cfg_we && (cfg_idx == IDX_W'(k))) begin
        shadow_d[k] = cfg_word;
        pending_d   = 1'b1;
      end
    end
  end

  // Bank and pending registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      // NOTE: the banks are small flop arrays, not RAM, so they can and must clear on reset.
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------
  // S1: absolute differences, brightness, raw pixel, captured thresholds
  // ---------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [PIX_W-1:0] s1_raw_q, s1_raw_d;
  logic [V_W-1:0]   s1_v_q, s1_v_d;
  logic [C_W-1:0]   s1_dr_q [NCLS];
  logic [C_W-1:0]   s1_dr_d [NCLS];
  logic [C_W-1:0]   s1_dg_q [NCLS];
  logic [C_W-1:0]   s1_dg_d [NCLS];
  logic [C_W-1:0]   s1_db_q [NCLS];
  logic [C_W-1:0]   s1_db_d [NCLS];
  cls_thr_t         s1_thr_q [NCLS];
  cls_thr_t         s1_thr_d [NCLS];

  // Per-class channel differences against the active bank.
  always_comb begin
    s1_valid_d = i_valid;
    s1_raw_d   = {i_R, i_G, i_B};
    s1_v_d     = V_W'(i_R) + V_W'(i_G) + V_W'(i_B);
    for (int k = 0; k < NCLS; k++) begin
      s1_dr_d[k]  = abs_diff(i_R, active_q[k].r0);
      s1_dg_d[k]  = abs_diff(i_G, active_q[k].g0);
      s1_db_d[k]  = abs_diff(i_B, active_q[k].b0);
      s1_thr_d[k] = '{en: active_q[k].en, err: active_q[k].err,
                      vmin: active_q[k].vmin, vmax: active_q[k].vmax,
                      rep: active_q[k].rep};
    end
  end

  // ---------------------------------------------------------------------
  // S2: SAD and the three inclusive compares per class
  // ---------------------------------------------------------------------
  logic             s2_valid_q, s2_valid_d;
  logic [PIX_W-1:0] s2_raw_q, s2_raw_d;
  logic [NCLS-1:0]  s2_hit_vec_q, s2_hit_vec_d;
  logic [PIX_W-1:0] s2_rep_q [NCLS];
  logic [PIX_W-1:0] s2_rep_d [NCLS];
  logic [V_W-1:0]   sad [NCLS];

  // Class match vector; an inverted V window (vmin > vmax) can never hit.
  always_comb begin
    s2_valid_d   = s1_valid_q;
    s2_raw_d     = s1_raw_q;
    s2_hit_vec_d = '0;
    for (int k = 0; k < NCLS; k++) begin
      sad[k] = V_W'(s1_dr_q[k]) + V_W'(s1_dg_q[k]) + V_W'(s1_db_q[k]);
      s2_hit_vec_d[k] = s1_thr_q[k].en
                      && (sad[k] <= s1_thr_q[k].err)
                      && (s1_v_q >= s1_thr_q[k].vmin)
                      && (s1_v_q <= s1_thr_q[k].vmax);
      s2_rep_d[k] = s1_thr_q[k].rep;
    end
  end

  // ---------------------------------------------------------------------
  // S3: fixed-priority encode, lowest index wins
  // ---------------------------------------------------------------------
  logic             s3_valid_q, s3_valid_d;
  logic [PIX_W-1:0] s3_raw_q, s3_raw_d;
  logic [NCLS-1:0]  s3_hit_vec_q, s3_hit_vec_d;
  logic             s3_hit_q, s3_hit_d;
  logic [IDX_W-1:0] s3_cls_q, s3_cls_d;
  logic [PIX_W-1:0] s3_rep_q, s3_rep_d;

  // Scan from the top so the lowest matching index is the last assignment.
  always_comb begin
    s3_valid_d   = s2_valid_q;
    s3_raw_d     = s2_raw_q;
    s3_hit_vec_d = s2_hit_vec_q;
    s3_hit_d     = |s2_hit_vec_q;
    s3_cls_d     = '0;
    s3_rep_d     = '0;
    for (int k = NCLS - 1; k >= 0; k--) begin
      if (s2_hit_vec_q[k]) begin
        s3_cls_d = IDX_W'(k);
        s3_rep_d = s2_rep_q[k];
      end
    end
  end

  // ---------------------------------------------------------------------
  // S4: output register; data holds through bubbles
  // ---------------------------------------------------------------------
  logic             o_valid_q, o_valid_d;
  logic [PIX_W-1:0] o_col_q, o_col_d;
  logic [PIX_W-1:0] o_raw_q, o_raw_d;
  logic             o_hit_q, o_hit_d;
  logic [IDX_W-1:0] o_cls_q, o_cls_d;
  logic [NCLS-1:0]  o_hit_vec_q, o_hit_vec_d;

  // Output colour mux: replacement or raw on hit, MISS_COLOR otherwise.
  always_comb begin
    o_valid_d   = s3_valid_q;
    o_col_d     = o_col_q;
    o_raw_d     = o_raw_q;
    o_hit_d     = o_hit_q;
    o_cls_d     = o_cls_q;
    o_hit_vec_d = o_hit_vec_q;
    if (s3_valid_q) begin
      o_raw_d     = s3_raw_q;
      o_hit_d     = s3_hit_q;
      o_cls_d     = s3_cls_q;
      o_hit_vec_d = s3_hit_vec_q;
      if (!s3_hit_q)     o_col_d = MISS_COLOR;
      else if (PASS_RAW) o_col_d = s3_raw_q;
      else               o_col_d = s3_rep_q;
    end
  end

  // Pipeline registers; reset drops every in-flight pixel.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_raw_q     <= '0;
      s1_v_q       <= '0;
      s1_dr_q      <= '{default: '0};
      s1_dg_q      <= '{default: '0};
      s1_db_q      <= '{default: '0};
      s1_thr_q     <= '{default: '0};
      s2_valid_q   <= 1'b0;
      s2_raw_q     <= '0;
      s2_hit_vec_q <= '0;
      s2_rep_q     <= '{default: '0};
      s3_valid_q   <= 1'b0;
      s3_raw_q     <= '0;
      s3_hit_vec_q <= '0;
      s3_hit_q     <= 1'b0;
      s3_cls_q     <= '0;
      s3_rep_q     <= '0;
      o_valid_q    <= 1'b0;
      o_col_q      <= '0;
      o_raw_q      <= '0;
      o_hit_q      <= 1'b0;
      o_cls_q      <= '0;
      o_hit_vec_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_raw_q     <= s1_raw_d;
      s1_v_q       <= s1_v_d;
      s1_dr_q      <= s1_dr_d;
      s1_dg_q      <= s1_dg_d;
      s1_db_q      <= s1_db_d;
      s1_thr_q     <= s1_thr_d;
      s2_valid_q   <= s2_valid_d;
      s2_raw_q     <= s2_raw_d;
      s2_hit_vec_q <= s2_hit_vec_d;
      s2_rep_q     <= s2_rep_d;
      s3_valid_q   <= s3_valid_d;
      s3_raw_q     <= s3_raw_d;
      s3_hit_vec_q <= s3_hit_vec_d;
      s3_hit_q     <= s3_hit_d;
      s3_cls_q     <= s3_cls_d;
      s3_rep_q     <= s3_rep_d;
      o_valid_q    <= o_valid_d;
      o_col_q      <= o_col_d;
      o_raw_q      <= o_raw_d;
      o_hit_q      <= o_hit_d;
      o_cls_q      <= o_cls_d;
      o_hit_vec_q  <= o_hit_vec_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_R       = o_col_q[3*C_W-1:2*C_W];
  assign o_G       = o_col_q[2*C_W-1:C_W];
  assign o_B       = o_col_q[C_W-1:0];
  assign o_R_raw   = o_raw_q[3*C_W-1:2*C_W];
  assign o_G_raw   = o_raw_q[2*C_W-1:C_W];
  assign o_B_raw   = o_raw_q[C_W-1:0];
  assign o_hit     = o_hit_q;
  assign o_cls     = o_cls_q;
  assign o_hit_vec = o_hit_vec_q;

endmodule
